// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU/DMA external bus controller.
package cpu_bus_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RECOVER = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_arb2.sv
// Two-requester arbiter: fixed priority to port 0, or round-robin using a
// last-grant pointer that is updated only when the controller takes a grant.
module bus_arb2
    import cpu_bus_pkg::*;
#(
    parameter int FIXED_PRI = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_valid,
    output logic o_grant
);

    logic r_last;
    logic w_grant;

    // Winner selection; a contested round-robin grant goes to the port not served last
    always_comb begin
        w_grant = PORT0;
        if (i_req0 && i_req1) begin
            if (FIXED_PRI != 0) begin
                w_grant = PORT0;
            end else begin
                w_grant = (r_last == PORT1) ? PORT0 : PORT1;
            end
        end else if (i_req1) begin
            w_grant = PORT1;
        end else begin
            w_grant = PORT0;
        end
    end

    assign o_valid = i_req0 | i_req1;
    assign o_grant = w_grant;

    // Last-grant pointer, starting at port 1 so port 0 wins the first contest
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= PORT1;
        end else if (i_take) begin
            r_last <= w_grant;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/cpu_bus_ctl.sv
// External bus controller shared by the CPU (port 0) and DMA loader (port 1):
// one transfer at a time, with ready timeout and a recovery phase.
module cpu_bus_ctl
    import cpu_bus_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int TIMEOUT   = 255,
    parameter int FIXED_PRI = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic          o_err0,
    output logic          o_err1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic          o_bus_clk,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [DW-1:0] o_bus_data,
    input  logic [DW-1:0] i_bus_data,
    input  logic          i_bus_data_ready,
    output logic          o_busy
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    bus_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_gnt;
    logic          r_bus_clk;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_data;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_busy;

    logic          w_valid;
    logic          w_grant;
    logic          w_take;
    logic          w_done;
    logic          w_tmo;
    logic [DW-1:0] w_rdata;

    bus_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    assign w_take  = (r_state == ST_IDLE) && w_valid;
    assign w_tmo   = (r_state == ST_ACTIVE) && !i_bus_data_ready && (r_cnt == CNT_MAX);
    assign w_done  = (r_state == ST_ACTIVE) && (i_bus_data_ready || (r_cnt == CNT_MAX));
    // A timed-out read returns all ones so software can recognise the abort
    assign w_rdata = w_tmo ? {DW{1'b1}} : i_bus_data;

    // Transfer FSM with timeout counter and registered bus/requester outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_gnt      <= PORT0;
            r_bus_clk  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= {AW{1'b0}};
            r_bus_data <= {DW{1'b0}};
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= {DW{1'b0}};
            r_rdata1   <= {DW{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_gnt      <= w_grant;
                        r_bus_we   <= (w_grant == PORT1) ? i_we1    : i_we0;
                        r_bus_addr <= (w_grant == PORT1) ? i_addr1  : i_addr0;
                        r_bus_data <= (w_grant == PORT1) ? i_wdata1 : i_wdata0;
                        r_bus_clk  <= 1'b1;
                        r_cnt      <= {CW{1'b0}};
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_done) begin
                        r_bus_clk <= 1'b0;
                        r_state   <= ST_RECOVER;
                        if (r_gnt == PORT0) begin
                            r_ack0 <= 1'b1;
                            r_err0 <= w_tmo;
                            if (!r_bus_we) begin
                                r_rdata0 <= w_rdata;
                            end
                        end else begin
                            r_ack1 <= 1'b1;
                            r_err1 <= w_tmo;
                            if (!r_bus_we) begin
                                r_rdata1 <= w_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    if (!i_bus_data_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_clk <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_err0     = r_err0;
    assign o_err1     = r_err1;
    assign o_rdata0   = r_rdata0;
    assign o_rdata1   = r_rdata1;
    assign o_bus_clk  = r_bus_clk;
    assign o_bus_we   = r_bus_we;
    assign o_bus_addr = r_bus_addr;
    assign o_bus_data = r_bus_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_cpu_bus_ctl.sv
// Self-checking bench: a round-robin and a fixed-priority controller share one
// stimulus stream and are checked against a transaction-level model.
module tb_cpu_bus_ctl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, bus_rdata;
    logic        bus_ready;

    logic        ack0 [2], ack1 [2], err0 [2], err1 [2];
    logic        bus_clk [2], bus_we [2], busy [2];
    logic [31:0] rdata0 [2], rdata1 [2], bus_addr [2], bus_wd [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd [2][2];

    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 fixed priority
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_bus_ctl #(.AW(32), .DW(32), .TIMEOUT(TMO), .FIXED_PRI(g)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
            .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
            .o_ack0(ack0[g]), .o_ack1(ack1[g]), .o_err0(err0[g]), .o_err1(err1[g]),
            .o_rdata0(rdata0[g]), .o_rdata1(rdata1[g]),
            .o_bus_clk(bus_clk[g]), .o_bus_we(bus_we[g]), .o_bus_addr(bus_addr[g]),
            .o_bus_data(bus_wd[g]), .i_bus_data(bus_rdata), .i_bus_data_ready(bus_ready),
            .o_busy(busy[g])
        );
    end

    function automatic logic ack_of(input int d, input int p);
        return (p == 0) ? ack0[d] : ack1[d];
    endfunction

    function automatic logic err_of(input int d, input int p);
        return (p == 0) ? err0[d] : err1[d];
    endfunction

    function automatic logic [31:0] rd_of(input int d, input int p);
        return (p == 0) ? rdata0[d] : rdata1[d];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_rd[d][0] = 32'h0;
            exp_rd[d][1] = 32'h0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        bus_rdata = 32'h0; bus_ready = 1'b0;
        clear_model();
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({bus_clk[d], bus_we[d], ack0[d], ack1[d], err0[d], err1[d], busy[d]} !== 7'b0 ||
                    bus_addr[d] !== 32'h0 || bus_wd[d] !== 32'h0 ||
                    rdata0[d] !== 32'h0 || rdata1[d] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d: got clk=%b we=%b ack=%b%b err=%b%b busy=%b addr=%h rd0=%h rd1=%h, expected all zero",
                             d, bus_clk[d], bus_we[d], ack0[d], ack1[d], err0[d], err1[d], busy[d],
                             bus_addr[d], rdata0[d], rdata1[d]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    // One transfer from port p with only that port requesting; dly = ready-low cycles
    task automatic run_single(input int p, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly);
        int waits;
        bit tmo;
        bit got;
        int exp_e;
        tmo   = (dly > TMO);
        exp_e = tmo ? TMO + 1 : dly + 1;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        bus_ready = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (bus_clk[d] !== 1'b1 || busy[d] !== 1'b1 || bus_addr[d] !== a ||
                bus_we[d] !== we || (we && bus_wd[d] !== wd)) begin
                n_fail++;
                $display("FAIL strobe dut%0d p%0d: got clk=%b busy=%b addr=%h we=%b data=%h, expected 1 1 %h %b %h",
                         d, p, bus_clk[d], busy[d], bus_addr[d], bus_we[d], bus_wd[d], a, we, wd);
            end
        end
        waits = 0;
        got   = 1'b0;
        while (!got && waits <= 40) begin
            @(negedge clk);
            if (ack_of(0, p) === 1'b1) begin
                got = 1'b1;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (bus_clk[d] !== 1'b1 || bus_addr[d] !== a || bus_we[d] !== we) begin
                        n_fail++;
                        $display("FAIL bus_hold dut%0d: got clk=%b addr=%h we=%b, expected 1 %h %b",
                                 d, bus_clk[d], bus_addr[d], bus_we[d], a, we);
                    end
                end
                if (!tmo && waits == dly) begin
                    bus_ready = 1'b1;
                    bus_rdata = rd;
                end
                waits++;
            end
        end
        n_checks++;
        if (!got || waits != exp_e) begin
            n_fail++;
            $display("FAIL ack_latency p%0d: got ack=%b after %0d cycles, expected ack after %0d cycles",
                     p, got, waits, exp_e);
        end
        for (int d = 0; d < 2; d++) begin
            if (!we) exp_rd[d][p] = tmo ? 32'hFFFF_FFFF : rd;
            n_checks++;
            if ({ack_of(d, p), ack_of(d, 1 - p), err_of(d, p), err_of(d, 1 - p), bus_clk[d]} !==
                {1'b1, 1'b0, tmo, 1'b0, 1'b0} ||
                rd_of(d, p) !== exp_rd[d][p] || rd_of(d, 1 - p) !== exp_rd[d][1 - p]) begin
                n_fail++;
                $display("FAIL completion dut%0d p%0d: got ack=%b/%b err=%b/%b clk=%b rd=%h/%h, expected 1/0 %b/0 0 %h/%h",
                         d, p, ack_of(d, p), ack_of(d, 1 - p), err_of(d, p), err_of(d, 1 - p), bus_clk[d],
                         rd_of(d, p), rd_of(d, 1 - p), tmo, exp_rd[d][p], exp_rd[d][1 - p]);
            end
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({ack0[d], ack1[d], err0[d], err1[d], busy[d], bus_clk[d]} !== 6'b0 ||
                rd_of(d, p) !== exp_rd[d][p]) begin
                n_fail++;
                $display("FAIL after_ack dut%0d: got ack=%b%b err=%b%b busy=%b clk=%b rd=%h, expected zeros rd=%h",
                         d, ack0[d], ack1[d], err0[d], err1[d], busy[d], bus_clk[d], rd_of(d, p), exp_rd[d][p]);
            end
        end
    endtask

    task automatic test_read_basic();
        run_single(0, 1'b0, 32'h0000_1234, $urandom, 32'h0000_00A5, 2);
    endtask

    task automatic test_timeout();
        run_single(1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, $urandom, 99);
        run_single(0, 1'b0, $urandom, $urandom, $urandom, TMO + 1);
        run_single(0, 1'b0, $urandom, $urandom, $urandom, TMO);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                       $urandom, int'($urandom_range(0, 11)));
        end
    endtask

    task automatic test_recover_hold();
        logic [31:0] a1, wd1, rd;
        a1 = $urandom; wd1 = $urandom; rd = $urandom;
        req0 = 1'b1; we0 = 1'b0; addr0 = $urandom;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = a1; wdata1 = wd1;
        @(negedge clk);
        bus_ready = 1'b1; bus_rdata = rd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_rd[d][0] = rd;
            n_checks++;
            if (ack0[d] !== 1'b1 || rdata0[d] !== rd) begin
                n_fail++;
                $display("FAIL hold_ack0 dut%0d: got ack0=%b rd0=%h, expected 1 %h", d, ack0[d], rdata0[d], rd);
            end
        end
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({bus_clk[d], busy[d], ack0[d], ack1[d]} !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL recover_hold dut%0d c%0d: got clk=%b busy=%b ack=%b%b, expected 0 1 00",
                             d, c, bus_clk[d], busy[d], ack0[d], ack1[d]);
                end
            end
        end
        bus_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (bus_clk[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL recover_exit dut%0d: got clk=%b busy=%b, expected 0 0", d, bus_clk[d], busy[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (bus_clk[d] !== 1'b1 || bus_addr[d] !== a1 || bus_we[d] !== 1'b1 || bus_wd[d] !== wd1) begin
                n_fail++;
                $display("FAIL pending_grant dut%0d: got clk=%b addr=%h we=%b data=%h, expected 1 %h 1 %h",
                         d, bus_clk[d], bus_addr[d], bus_we[d], bus_wd[d], a1, wd1);
            end
        end
        bus_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack1[d] !== 1'b1 || err1[d] !== 1'b0 || ack0[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL pending_ack dut%0d: got ack1=%b err1=%b ack0=%b, expected 1 0 0",
                         d, ack1[d], err1[d], ack0[d]);
            end
        end
        req1 = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int last [2];
        int win [2];
        logic [31:0] dat;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        last[0] = 1; last[1] = 1;
        addr0 = $urandom; addr1 = addr0 ^ 32'h0000_0010;
        we0 = 1'b0; we1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 2; d++) begin
                win[d]  = (d == 1) ? 0 : 1 - last[d];
                last[d] = win[d];
            end
            dat = $urandom;
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (bus_clk[d] !== 1'b1 || bus_addr[d] !== ((win[d] == 1) ? addr1 : addr0)) begin
                    n_fail++;
                    $display("FAIL arb_grant dut%0d round%0d: got clk=%b addr=%h, expected port %0d addr %h",
                             d, r, bus_clk[d], bus_addr[d], win[d], (win[d] == 1) ? addr1 : addr0);
                end
            end
            bus_ready = 1'b1; bus_rdata = dat;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_rd[d][win[d]] = dat;
                n_checks++;
                if (ack_of(d, win[d]) !== 1'b1 || ack_of(d, 1 - win[d]) !== 1'b0 ||
                    rd_of(d, win[d]) !== dat) begin
                    n_fail++;
                    $display("FAIL arb_ack dut%0d round%0d: got ack=%b%b rd=%h, expected port %0d rd %h",
                             d, r, ack1[d], ack0[d], rd_of(d, win[d]), win[d], dat);
                end
            end
            bus_ready = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (busy[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arb_idle dut%0d round%0d: got busy=%b, expected 0", d, r, busy[d]);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = $urandom;
        bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (bus_clk[d] !== 1'b0 || busy[d] !== 1'b0 || bus_addr[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got clk=%b busy=%b addr=%h, expected 0 0 0",
                         d, bus_clk[d], busy[d], bus_addr[d]);
            end
        end
        req0 = 1'b0;
        clear_model();
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({ack0[d], ack1[d], err0[d], err1[d]} !== 4'b0) begin
                    n_fail++;
                    $display("FAIL reset_no_ack dut%0d: got ack=%b%b err=%b%b, expected 0000",
                             d, ack0[d], ack1[d], err0[d], err1[d]);
                end
            end
        end
        rst_n = 1'b1;
        run_single(0, 1'b0, $urandom, $urandom, $urandom, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_timeout();
        test_random();
        test_recover_hold();
        test_arbitration();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctl.md
CPU_BUS_CTL -- requirements
Module: cpu_bus_ctl

Interface
REQ-001 Parameter AW, default 32, external bus address width.
REQ-002 Parameter DW, default 32, external bus data width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent waiting for i_bus_data_ready before abort.
REQ-004 Parameter FIXED_PRI, default 1: 1 = port 0 (CPU) always wins; 0 = round-robin.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_req0 / i_req1  input  1  transfer request, port 0 (CPU) / port 1 (DMA loader).
REQ-009 i_we0 / i_we1  input  1  1 = write, 0 = read.
REQ-010 i_addr0 / i_addr1  input  AW  transfer address.
REQ-011 i_wdata0 / i_wdata1  input  DW  write data.
REQ-012 o_ack0 / o_ack1  output  1  one-cycle completion pulse.
REQ-013 o_err0 / o_err1  output  1  one-cycle pulse coincident with ack on timeout.
REQ-014 o_rdata0 / o_rdata1  output  DW  read data, valid from the ack cycle until the next ack on that port.
REQ-015 o_bus_clk  output  1  bus strobe; high while a transfer is active.
REQ-016 o_bus_we  output  1  bus write enable.
REQ-017 o_bus_addr  output  AW  bus address.
REQ-018 o_bus_data  output  DW  bus write data.
REQ-019 i_bus_data  input  DW  bus read data.
REQ-020 i_bus_data_ready  input  1  target completion; held high until o_bus_clk falls.
REQ-021 o_busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE, ACTIVE, RECOVER.
REQ-023 IDLE, any request sampled: latch the winner's addr/we/wdata onto the bus outputs, set o_bus_clk=1, record grant, go to ACTIVE. Request at cycle N gives o_bus_clk high at N+1.
REQ-024 Arbitration, both requests in one cycle:
  - FIXED_PRI=1: port 0 wins.
  - FIXED_PRI=0: the port not granted last wins; after reset the last-grant pointer is port 1, so port 0 wins first.
REQ-025 ACTIVE, i_bus_data_ready=1:
  - o_bus_clk=0 on the next cycle.
  - Pulse the granted o_ackN for one cycle.
  - For a read, capture i_bus_data into the granted o_rdataN.
  - Go to RECOVER. Ready at cycle M gives ack at M+1.
REQ-026 ACTIVE: increment a timeout counter each cycle ready is low. When it reaches TIMEOUT:
  - Drop o_bus_clk.
  - Pulse o_ackN and o_errN.
  - For a read, load o_rdataN with all ones.
  - Go to RECOVER.
REQ-027 RECOVER: remain until i_bus_data_ready=0, then go to IDLE. Minimum one cycle.
REQ-028 Requesters hold req, addr, we and wdata stable until ack, and may drop req in the ack cycle; requests are not sampled in ACTIVE or RECOVER.
REQ-029 Bus address, data and we outputs hold their values from grant through RECOVER exit; they do not change while o_bus_clk is high.
REQ-030 The non-granted port's request stays pending and is served on the next IDLE entry; no request is dropped.
REQ-031 Back-to-back throughput: one transfer per 3 cycles minimum (IDLE, ACTIVE with immediate ready, RECOVER).
REQ-032 Timeout counter width is ceil(log2(TIMEOUT+1)); the counter clears on every entry to ACTIVE.

Reset
REQ-033 While i_rst_n=0, all of the following are 0, asynchronously:
  - state = IDLE.
  - o_bus_clk, o_bus_we, o_bus_addr, o_bus_data.
  - o_ack*, o_err*, o_rdata*.
  - o_busy and the timeout counter.
  - The last-grant pointer is set to port 1.
REQ-034 Reset asserted mid-transfer drops o_bus_clk immediately; no ack or err is issued for the aborted transfer.
REQ-035 First request is sampled on the first rising edge after i_rst_n deasserts.

Structure
REQ-036 Shared package cpu_bus_pkg holds the FSM state enum, the AW/DW defaults and the port-index constants.
REQ-037 The 2-way arbiter (fixed/round-robin select plus last-grant pointer) is a sub-module, bus_arb2.
REQ-038 The FSM, timeout counter and bus output registers live in cpu_bus_ctl.

Verification
REQ-039 Port 0 read at 0x0000_1234, ready after 2 cycles with data 0xA5 -> o_bus_clk high 1 cycle after req; o_ack0 pulse with o_rdata0=0x0000_00A5; o_bus_we=0 throughout.
REQ-040 Both ports request in the same cycle, FIXED_PRI=0, three rounds -> grants alternate 0,1,0; FIXED_PRI=1 -> port 0 every round while it keeps requesting.
REQ-041 Port 1 write 0xDEADBEEF to 0x0000_0200, ready never asserted, TIMEOUT=8 -> o_ack1 and o_err1 pulse 9 cycles after strobe; o_bus_clk low.
REQ-042 Reset asserted 1 cycle into ACTIVE -> o_bus_clk=0 without waiting for a clock edge; no ack; the next request after release is granted normally.
REQ-043 Ready held high 3 cycles after ack -> FSM stays in RECOVER; a pending port 1 request is not strobed until ready falls.
